vga_pixel_framebuffer: RTL and testbench

// - Sink end of the pixel-plot interface (X, Y, Colour, Plot) that animation blocks drive.
// - Stores plotted pixels in an on-chip X_SCREENSIZE x Y_SCREENSIZE x 3-bit frame buffer.
// - Continuously scans the buffer out in raster order with sync/valid timing for the display stage.
// - Sits between drawing FSMs and the VGA DAC/monitor model.

---
 rtl/vga_pixel_framebuffer_if.sv | 18 +
 rtl/vga_pixel_framebuffer.sv | 192 +++++++++++++++++++
 tb/tb_vga_pixel_framebuffer.sv | 396 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pixel_framebuffer_if.sv
// -----------------------------------------------------------------------------
// vga_pixel_framebuffer_if
// Pixel-plot bus between a drawing block (master) and the frame buffer
// (slave). One pixel is written on each clock that iPlot is high.
//   iX       [7:0]  plot column
//   iY       [6:0]  plot row
//   iColour  [2:0]  plot colour
//   iPlot           write strobe
// -----------------------------------------------------------------------------
interface vga_pixel_framebuffer_if;
   logic [7:0] iX;
   logic [6:0] iY;
   logic [2:0] iColour;
   logic       iPlot;

   modport master (output iX, iY, iColour, iPlot);
   modport slave  (input  iX, iY, iColour, iPlot);
endinterface

// File: rtl/vga_pixel_framebuffer.sv
// -----------------------------------------------------------------------------
// vga_pixel_framebuffer
// Stores plotted pixels in an X_SCREENSIZE x Y_SCREENSIZE x 3-bit buffer and
// scans it out continuously in raster order with line/frame sync.
//
// Ports
//   iClock       system clock, rising edge
//   iReset       synchronous active-high reset
//   plot         pixel-plot bus (slave side: iX, iY, iColour, iPlot)
//   oScanX/Y     coordinate of the pixel on oScanColour (0 when not visible)
//   oScanColour  pixel colour read from the buffer (0 when not visible)
//   oScanValid   oScan* carry a visible pixel
//   oHSync       line sync, H_SYNC clocks starting at h = X_SCREENSIZE+1
//   oVSync       frame sync, the whole first blank line
//   oBusy        buffer clear sweep in progress
//   oDropCount   saturating count of out-of-range plots
//
// Optional feature: define FB_CLEAR_EN to fill the buffer with CLEAR_COLOUR
// after every reset. Without it the buffer powers up undefined and oBusy is 0.
// -----------------------------------------------------------------------------
module vga_pixel_framebuffer #(
   parameter int         X_SCREENSIZE = 160,
   parameter int         Y_SCREENSIZE = 120,
   parameter int         H_BLANK      = 8,
   parameter int         V_BLANK      = 4,
   parameter int         H_SYNC       = 4,
   parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
   input  logic                   iClock,
   input  logic                   iReset,
   vga_pixel_framebuffer_if.slave plot,
   output logic [7:0]             oScanX,
   output logic [6:0]             oScanY,
   output logic [2:0]             oScanColour,
   output logic                   oScanValid,
   output logic                   oHSync,
   output logic                   oVSync,
   output logic                   oBusy,
   output logic [7:0]             oDropCount
);

   localparam int          DEPTH      = X_SCREENSIZE * Y_SCREENSIZE;
   localparam logic [7:0]  H_VIS      = 8'(X_SCREENSIZE);
   localparam logic [7:0]  H_LAST     = 8'(X_SCREENSIZE + H_BLANK - 1);
   localparam logic [7:0]  HS_FIRST   = 8'(X_SCREENSIZE + 1);
   localparam logic [7:0]  HS_LAST    = 8'(X_SCREENSIZE + H_SYNC);
   localparam logic [6:0]  V_VIS      = 7'(Y_SCREENSIZE);
   localparam logic [6:0]  V_LAST     = 7'(Y_SCREENSIZE + V_BLANK - 1);
   localparam logic [14:0] ROW_STRIDE = 15'(X_SCREENSIZE);

   logic [2:0]  mem_q [DEPTH];

   logic [7:0]  h_q, h_d;
   logic [6:0]  v_q, v_d;
   logic [7:0]  drop_q, drop_d;
   logic [7:0]  scan_x_q;
   logic [6:0]  scan_y_q;
   logic [2:0]  scan_colour_q;
   logic        scan_valid_q, hsync_q, vsync_q;

   logic        sweep_wr;     // sweep owns the write port this cycle
   logic        plot_block;   // plots are ignored (sweep running or oBusy high)
   logic [14:0] sweep_addr;
   logic        busy;

   logic        plot_in_range, scan_vis, mem_we;
   logic [14:0] plot_addr, scan_addr, mem_waddr;
   logic [2:0]  mem_wdata;

`ifdef FB_CLEAR_EN
   localparam logic [14:0] LAST_ADDR = 15'(DEPTH - 1);

   typedef enum logic {ST_CLEAR, ST_RUN} state_e;

   state_e      state_q, state_d;
   logic [14:0] clr_addr_q, clr_addr_d;
   logic        busy_q, busy_d;

   always_ff @(posedge iClock) begin
      if (iReset) begin
         state_q    <= ST_CLEAR;
         clr_addr_q <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
         busy_q     <= busy_d;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      busy_d     = 1'b0;
      case (state_q)
         ST_CLEAR: begin
            busy_d     = 1'b1;
            clr_addr_d = clr_addr_q + 15'd1;
            if (clr_addr_q == LAST_ADDR) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: ;
      endcase
   end

   // busy_q trails the sweep by one edge, so oBusy rises on the first
   // post-reset edge and stays high for exactly DEPTH cycles.
   assign sweep_wr   = (state_q == ST_CLEAR);
   assign plot_block = sweep_wr || busy_q;
   assign sweep_addr = clr_addr_q;
   assign busy       = busy_q;
`else
   assign sweep_wr   = 1'b0;
   assign plot_block = 1'b0;
   assign sweep_addr = '0;
   assign busy       = 1'b0;
`endif

   // Raster counters: h wraps every line, v steps on each h wrap.
   always_comb begin
      h_d = h_q + 8'd1;
      v_d = v_q;
      if (h_q == H_LAST) begin
         h_d = '0;
         v_d = (v_q == V_LAST) ? '0 : v_q + 7'd1;
      end
   end

   assign plot_in_range = (plot.iX < H_VIS) && (plot.iY < V_VIS);
   assign plot_addr     = 15'(plot.iY) * ROW_STRIDE + 15'(plot.iX);
   assign scan_addr     = 15'(v_q) * ROW_STRIDE + 15'(h_q);
   assign scan_vis      = (h_q < H_VIS) && (v_q < V_VIS) && !plot_block;

   assign mem_we    = !iReset && (sweep_wr || (plot.iPlot && !plot_block && plot_in_range));
   assign mem_waddr = sweep_wr ? sweep_addr : plot_addr;
   assign mem_wdata = sweep_wr ? CLEAR_COLOUR : plot.iColour;

   always_comb begin
      drop_d = drop_q;
      if (plot.iPlot && !plot_block && !plot_in_range && (drop_q != 8'hFF)) begin
         drop_d = drop_q + 8'd1;
      end
   end

   // NOTE: the buffer array has no reset; clearing 19200 words needs the
   // sweep, and a reset branch here would stop it mapping onto block RAM.
   always_ff @(posedge iClock) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   // NOTE: non-blocking assignments make the read below see the array as it
   // was before this edge, so a same-cycle write to the scanned address
   // returns the old colour.
   always_ff @(posedge iClock) begin
      if (iReset) begin
         h_q           <= '0;
         v_q           <= '0;
         drop_q        <= '0;
         scan_valid_q  <= 1'b0;
         scan_x_q      <= '0;
         scan_y_q      <= '0;
         scan_colour_q <= '0;
         hsync_q       <= 1'b0;
         vsync_q       <= 1'b0;
      end else begin
         h_q           <= h_d;
         v_q           <= v_d;
         drop_q        <= drop_d;
         scan_valid_q  <= scan_vis;
         scan_x_q      <= scan_vis ? h_q : '0;
         scan_y_q      <= scan_vis ? v_q : '0;
         scan_colour_q <= scan_vis ? mem_q[scan_addr] : '0;
         hsync_q       <= (h_q >= HS_FIRST) && (h_q <= HS_LAST);
         vsync_q       <= (v_q == V_VIS);
      end
   end

   assign oScanX      = scan_x_q;
   assign oScanY      = scan_y_q;
   assign oScanColour = scan_colour_q;
   assign oScanValid  = scan_valid_q;
   assign oHSync      = hsync_q;
   assign oVSync      = vsync_q;
   assign oBusy       = busy;
   assign oDropCount  = drop_q;

endmodule

// File: tb/tb_vga_pixel_framebuffer.sv
// -----------------------------------------------------------------------------
// tb_vga_pixel_framebuffer
// Self-checking bench. The reference model is the raster position p, counted
// in clocks since reset, turned into (h, v, sync) with plain arithmetic, plus
// an array holding the colour last plotted at each pixel.
// -----------------------------------------------------------------------------
module tb_vga_pixel_framebuffer;

   localparam int         XS      = 160;
   localparam int         YS      = 120;
   localparam int         HT      = 168;
   localparam int         VT      = 124;
   localparam int         FRAME   = HT * VT;
   localparam int         DEPTH   = XS * YS;
   localparam logic [2:0] CLEAR_C = 3'b000;

   logic       iClock = 1'b0;
   logic       iReset = 1'b1;
   logic [7:0] oScanX;
   logic [6:0] oScanY;
   logic [2:0] oScanColour;
   logic       oScanValid, oHSync, oVSync, oBusy;
   logic [7:0] oDropCount;

   vga_pixel_framebuffer_if plot_bus ();

   vga_pixel_framebuffer dut (
      .iClock      (iClock),
      .iReset      (iReset),
      .plot        (plot_bus),
      .oScanX      (oScanX),
      .oScanY      (oScanY),
      .oScanColour (oScanColour),
      .oScanValid  (oScanValid),
      .oHSync      (oHSync),
      .oVSync      (oVSync),
      .oBusy       (oBusy),
      .oDropCount  (oDropCount)
   );

   always #5 iClock = ~iClock;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         k        = 0;   // edges since the last reset edge
   int         ref_drops = 0;
   logic [2:0] ref_mem [DEPTH];
   bit         known   [DEPTH];

   logic [17:0] scan_obs;
   assign scan_obs = {oScanValid, oScanX, oScanY, oHSync, oVSync};

   // One clock; outputs are sampled at the following falling edge.
   task automatic tick();
      @(posedge iClock);
      if (iReset) begin
         k = 0;
         ref_drops = 0;
      end else begin
         k++;
      end
      @(negedge iClock);
   endtask

   // Expected {valid, x, y, hsync, vsync} for raster position p.
   function automatic logic [17:0] exp_scan(input int p);
      int   h, v;
      logic vis;
      h   = p % HT;
      v   = (p / HT) % VT;
      vis = (h < XS) && (v < YS);
      exp_scan = {vis, vis ? 8'(h) : 8'd0, vis ? 7'(v) : 7'd0,
                  (h >= XS + 1) && (h < XS + 5), v == YS};
   endfunction

   task automatic plot(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
      plot_bus.iX      = x;
      plot_bus.iY      = y;
      plot_bus.iColour = c;
      plot_bus.iPlot   = 1'b1;
      tick();
      plot_bus.iPlot   = 1'b0;
      if (x < XS && y < YS) begin
         ref_mem[int'(y) * XS + int'(x)] = c;
         known[int'(y) * XS + int'(x)]   = 1'b1;
      end else if (ref_drops < 255) begin
         ref_drops++;
      end
   endtask

   task automatic pulse_reset();
      iReset = 1'b1;
      tick();
      iReset = 1'b0;
   endtask

   task automatic test_reset();
      plot_bus.iX    = 8'd200;
      plot_bus.iY    = 7'd0;
      plot_bus.iPlot = 1'b1;
      iReset = 1'b1;
      tick();
      tick();
      plot_bus.iPlot = 1'b0;
      n_checks++;
      if ({scan_obs, oScanColour} !== 21'd0) begin
         n_fail++;
         $display("FAIL reset_scan got %h want 0", {scan_obs, oScanColour});
      end
      n_checks++;
      if (oDropCount !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_drop got %0d want 0", oDropCount);
      end
      n_checks++;
      if (oBusy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_busy got %b want 0", oBusy);
      end
   endtask

   task automatic test_scan_timing();
      int p, n_valid, n_vs, line_valid;
      logic [17:0] e;
      pulse_reset();
      n_valid = 0; n_vs = 0; line_valid = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         tick();
         p = k - 1;
         e = exp_scan(p);
         n_checks++;
         if (scan_obs !== e) begin
            n_fail++;
            $display("FAIL scan_timing p=%0d got %h want %h", p, scan_obs, e);
         end
         if (oScanValid !== 1'b1) begin
            n_checks++;
            if (oScanColour !== 3'd0) begin
               n_fail++;
               $display("FAIL blank_colour p=%0d got %0d want 0", p, oScanColour);
            end
         end
         if (oScanValid === 1'b1) begin
            n_valid++;
            line_valid++;
         end
         if (oVSync === 1'b1) n_vs++;
         if (p % HT == HT - 1) begin
            n_checks++;
            if (line_valid != (((p % FRAME) / HT < YS) ? XS : 0)) begin
               n_fail++;
               $display("FAIL line_valid p=%0d got %0d", p, line_valid);
            end
            line_valid = 0;
         end
         if (p % FRAME == FRAME - 1) begin
            n_checks++;
            if (n_valid != DEPTH || n_vs != HT) begin
               n_fail++;
               $display("FAIL frame_counts valid=%0d want %0d vsync=%0d want %0d",
                        n_valid, DEPTH, n_vs, HT);
            end
            n_valid = 0;
            n_vs    = 0;
         end
      end
   endtask

   task automatic test_plot_readback();
      int  p, h, v, a;
      bit  seen;
      seen = 1'b0;
      // Scan is at the top of a frame; rows 2..20 are still ahead of it.
      plot(8'd0,   7'd0, 3'b110);
      plot(8'd5,   7'd7, 3'b101);
      plot(8'd159, 7'd2, 3'b011);
      plot(8'd20,  7'd3, 3'b001);
      plot(8'd20,  7'd3, 3'b110);
      for (int i = 0; i < 16; i++) begin
         plot(8'($urandom_range(0, 159)), 7'($urandom_range(3, 20)), 3'($urandom_range(0, 7)));
      end
      for (int i = 0; i < FRAME; i++) begin
         tick();
         p = (k - 1) % FRAME;
         h = p % HT;
         v = p / HT;
         if (v > 20) break;
         a = v * XS + h;
         if (v >= 2 && h < XS && known[a]) begin
            n_checks++;
            if (oScanValid !== 1'b1 || oScanColour !== ref_mem[a]) begin
               n_fail++;
               $display("FAIL readback (%0d,%0d) got v=%b c=%0d want c=%0d",
                        h, v, oScanValid, oScanColour, ref_mem[a]);
            end
         end
         if (oScanValid === 1'b1 && oScanX == 8'd5 && oScanY == 7'd7) begin
            seen = 1'b1;
            n_checks++;
            if (oScanColour !== 3'b101) begin
               n_fail++;
               $display("FAIL pixel_5_7 got %0d want 5", oScanColour);
            end
         end
      end
      n_checks++;
      if (!seen) begin
         n_fail++;
         $display("FAIL pixel_5_7 never scanned got none want one");
      end
   endtask

   task automatic test_same_address();
      logic [2:0] old_c;
      old_c = ref_mem[0];
      iReset = 1'b1;
      tick();
      iReset = 1'b0;
      plot_bus.iX      = 8'd0;
      plot_bus.iY      = 7'd0;
      plot_bus.iColour = 3'b010;
      plot_bus.iPlot   = 1'b1;
      tick();
      plot_bus.iPlot   = 1'b0;
      ref_mem[0] = 3'b010;
      n_checks++;
      if ({oScanValid, oScanX, oScanY, oScanColour} !== {1'b1, 8'd0, 7'd0, old_c}) begin
         n_fail++;
         $display("FAIL same_addr_old got %h want %h",
                  {oScanValid, oScanX, oScanY, oScanColour}, {1'b1, 8'd0, 7'd0, old_c});
      end
      for (int i = 0; i < FRAME + 8 && (k - 1) != FRAME; i++) tick();
      n_checks++;
      if ((k - 1) != FRAME || oScanValid !== 1'b1 || oScanColour !== 3'b010) begin
         n_fail++;
         $display("FAIL same_addr_new got %0d want 2", oScanColour);
      end
   endtask

   task automatic test_reset_mid_line();
      int          n_hs;
      logic [17:0] e;
      for (int i = 0; i < 50; i++) tick();
      iReset = 1'b1;
      tick();
      n_checks++;
      if ({scan_obs, oScanColour} !== 21'd0) begin
         n_fail++;
         $display("FAIL midline_reset got %h want 0", {scan_obs, oScanColour});
      end
      iReset = 1'b0;
      tick();
      n_checks++;
      if ({oScanValid, oScanX, oScanY} !== {1'b1, 8'd0, 7'd0}) begin
         n_fail++;
         $display("FAIL midline_restart got %h want 100", {oScanValid, oScanX, oScanY});
      end
      n_hs = 0;
      for (int i = 0; i < 3 * HT; i++) begin
         tick();
         e = exp_scan(k - 1);
         n_checks++;
         if (scan_obs !== e) begin
            n_fail++;
            $display("FAIL midline_resume p=%0d got %h want %h", k - 1, scan_obs, e);
         end
         if (oHSync === 1'b1) n_hs++;
      end
      n_checks++;
      if (n_hs != 12) begin
         n_fail++;
         $display("FAIL midline_hsync_count got %0d want 12", n_hs);
      end
   endtask

   task automatic test_drop();
      logic [7:0] x;
      logic [6:0] y;
      pulse_reset();
`ifdef FB_CLEAR_EN
      for (int i = 0; i < DEPTH + 10 && (k == 0 || oBusy === 1'b1); i++) tick();
`endif
      plot(8'd160, 7'd0, 3'b111);
      plot(8'd0, 7'd120, 3'b111);
      n_checks++;
      if (oDropCount !== 8'd2) begin
         n_fail++;
         $display("FAIL drop_two got %0d want 2", oDropCount);
      end
      plot(8'd159, 7'd119, 3'b001);
      plot_bus.iX = 8'd255;
      plot_bus.iY = 7'd127;
      tick();
      n_checks++;
      if (oDropCount !== 8'd2) begin
         n_fail++;
         $display("FAIL drop_edge_idle got %0d want 2", oDropCount);
      end
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            x = 8'($urandom_range(160, 255));
            y = 7'($urandom_range(0, 127));
         end else begin
            x = 8'($urandom_range(0, 255));
            y = 7'($urandom_range(120, 127));
         end
         plot(x, y, 3'($urandom_range(0, 7)));
         n_checks++;
         if (oDropCount !== 8'(ref_drops)) begin
            n_fail++;
            $display("FAIL drop_count i=%0d got %0d want %0d", i, oDropCount, ref_drops);
         end
      end
      n_checks++;
      if (oDropCount !== 8'd255) begin
         n_fail++;
         $display("FAIL drop_saturate got %0d want 255", oDropCount);
      end
   endtask

`ifdef FB_CLEAR_EN
   task automatic test_clear();
      int busy_cycles, valid_busy;
      pulse_reset();
      for (int i = 0; i < DEPTH + 10 && (k == 0 || oBusy === 1'b1); i++) tick();
      plot(8'd10, 7'd10, 3'b111);
      iReset = 1'b1;
      tick();
      n_checks++;
      if (oBusy !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_busy_in_reset got %b want 0", oBusy);
      end
      iReset = 1'b0;
      busy_cycles = 0;
      valid_busy  = 0;
      for (int i = 0; i < DEPTH + 100; i++) begin
         plot_bus.iX      = (i % 2 == 0) ? 8'd10 : 8'd200;
         plot_bus.iY      = 7'd10;
         plot_bus.iColour = 3'b101;
         plot_bus.iPlot   = 1'b1;
         tick();
         if (oBusy !== 1'b1) break;
         busy_cycles++;
         if (oScanValid === 1'b1) valid_busy++;
      end
      plot_bus.iPlot = 1'b0;
      n_checks++;
      if (busy_cycles != DEPTH) begin
         n_fail++;
         $display("FAIL clear_busy_len got %0d want %0d", busy_cycles, DEPTH);
      end
      n_checks++;
      if (valid_busy != 0) begin
         n_fail++;
         $display("FAIL clear_valid_while_busy got %0d want 0", valid_busy);
      end
      n_checks++;
      if (oDropCount !== 8'd0) begin
         n_fail++;
         $display("FAIL clear_drop got %0d want 0", oDropCount);
      end
      for (int i = 0; i < 2 * FRAME && (k - 1) != FRAME + 10 * HT + 10; i++) tick();
      n_checks++;
      if (oScanValid !== 1'b1 || oScanX !== 8'd10 || oScanY !== 7'd10 || oScanColour !== CLEAR_C) begin
         n_fail++;
         $display("FAIL clear_readback got v=%b (%0d,%0d) c=%0d want (10,10) c=%0d",
                  oScanValid, oScanX, oScanY, oScanColour, CLEAR_C);
      end
   endtask
`endif

   initial begin
      plot_bus.iX      = '0;
      plot_bus.iY      = '0;
      plot_bus.iColour = '0;
      plot_bus.iPlot   = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         ref_mem[i] = 3'd0;
         known[i]   = 1'b0;
      end
      test_reset();
`ifdef FB_CLEAR_EN
      test_clear();
`else
      test_scan_timing();
      test_plot_readback();
      test_same_address();
      test_reset_mid_line();
`endif
      test_drop();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
